// File: rtl/mac_rx_buffer_reader.sv
// rtl/mac_rx_buffer_reader.sv - MAC Rx packet buffer drain to valid/ready stream; RX_STATS_EN builds delivery counters
module mac_rx_buffer_reader #(
  parameter int ADDR_W  = 9,
  parameter int MAX_LEN = 1522
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W:0]   commited_wr_address,
  output logic [ADDR_W:0]   rd_addr_extended,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [63:0]       rd_data,
  output logic [63:0]       m_data,
  output logic [7:0]        m_keep,
  output logic              m_sop,
  output logic              m_eop,
  output logic [15:0]       m_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              err_resync,
  output logic [31:0]       pkt_count,
  output logic [31:0]       byte_count
);
  localparam int PW = ADDR_W + 1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HDR    = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        sop;
    logic        eop;
  } ent_t;

  logic [1:0]    state;
  logic [PW-1:0] c0, c1, commit_sync;
  logic [PW-1:0] rd_ptr, pkt_end, n_words, rd_cnt, rx_cnt, last_idx;
  logic [15:0]   len_q;
  logic [7:0]    keep_last;
  logic          in_flight;
  logic [1:0]    occ;
  ent_t          e0, e1, ent_new;
  logic [31:0]   hdr_len, hdr_words32;
  logic [7:0]    hdr_keep;
  logic          hdr_bad, have_data, pop, push, room, data_rd;
  logic [2:0]    pending;
  logic          unused_bits;

  // Header decode straight off the RAM port while in HDR
  assign hdr_len     = rd_data[63:32];
  assign hdr_words32 = (hdr_len + 32'd7) >> 3;
  assign hdr_bad     = (hdr_len == 32'd0) || (hdr_len > 32'(MAX_LEN));
  assign hdr_keep    = (hdr_len[2:0] == 3'd0) ? 8'hFF : ((8'd1 << hdr_len[2:0]) - 8'd1);
  assign unused_bits = ^{rd_data[31:0], hdr_words32[31:PW]};

  // Read scheduling: the first data read is issued in HDR so data lands 3 cycles after IDLE
  assign have_data = (rd_ptr != commit_sync);
  assign pop       = m_valid && m_ready;
  assign push      = in_flight;
  assign pending   = {1'b0, occ} + {2'b0, in_flight} - {2'b0, pop};
  assign room      = (pending < 3'd2);
  assign data_rd   = have_data &&
                     (((state == ST_HDR) && !hdr_bad) ||
                      ((state == ST_STREAM) && (rd_cnt != n_words) && room));
  assign rd_en     = ((state == ST_IDLE) && have_data) || data_rd;
  assign rd_addr   = rd_ptr[ADDR_W-1:0];
  assign last_idx  = n_words - PW'(1);

  // Tag each arriving word with its position in the packet
  always_comb begin
    ent_new      = '0;
    ent_new.data = rd_data;
    ent_new.sop  = (rx_cnt == '0);
    ent_new.eop  = (rx_cnt == last_idx);
    ent_new.keep = (rx_cnt == last_idx) ? keep_last : 8'hFF;
  end

  assign m_valid = (occ != 2'd0);
  assign m_data  = e0.data;
  assign m_keep  = m_valid ? e0.keep : 8'h00;
  assign m_sop   = m_valid && e0.sop;
  assign m_eop   = m_valid && e0.eop;
  assign m_len   = (m_valid && e0.sop) ? len_q : 16'd0;

  // Two-flop commit pointer sync; load only when both stages agree
  always_ff @(posedge clk) begin
    if (reset) begin
      c0          <= '0;
      c1          <= '0;
      commit_sync <= '0;
    end else begin
      c0 <= commited_wr_address;
      c1 <= c0;
      if (c0 == c1) commit_sync <= c1;
    end
  end

  // Packet FSM, read pointer and freed pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      rd_ptr           <= '0;
      rd_addr_extended <= '0;
      pkt_end          <= '0;
      n_words          <= '0;
      rd_cnt           <= '0;
      len_q            <= '0;
      keep_last        <= '0;
      err_resync       <= 1'b0;
      in_flight        <= 1'b0;
    end else begin
      err_resync <= 1'b0;
      in_flight  <= data_rd;
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case (state)
        ST_IDLE: begin
          if (have_data) state <= ST_HDR;
        end
        ST_HDR: begin
          if (hdr_bad) begin
            err_resync       <= 1'b1;
            rd_ptr           <= commit_sync;
            rd_addr_extended <= commit_sync;
            state            <= ST_IDLE;
          end else begin
            len_q     <= hdr_len[15:0];
            n_words   <= hdr_words32[PW-1:0];
            keep_last <= hdr_keep;
            pkt_end   <= rd_ptr + hdr_words32[PW-1:0];
            rd_cnt    <= PW'(data_rd);
            state     <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          rd_cnt <= rd_cnt + PW'(data_rd);
          if (pop && m_eop) begin
            rd_addr_extended <= pkt_end;
            state            <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Two-entry skid buffer; e0 is the head driving the stream
  always_ff @(posedge clk) begin
    if (reset) begin
      e0     <= '0;
      e1     <= '0;
      occ    <= 2'd0;
      rx_cnt <= '0;
    end else begin
      if (state == ST_HDR) rx_cnt <= '0;
      else if (push) rx_cnt <= rx_cnt + PW'(1);
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= ent_new;
          else e1 <= ent_new;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= ent_new;
          end else begin
            e0 <= e1;
            e1 <= ent_new;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RX_STATS_EN
  // Delivery counters, bumped once per completed packet
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else if (pop && m_eop) begin
      pkt_count  <= pkt_count + 32'd1;
      byte_count <= byte_count + {16'd0, len_q};
    end
  end
`else
  assign pkt_count  = 32'd0;
  assign byte_count = 32'd0;
`endif

endmodule

// File: doc/mac_rx_buffer_reader.md
Name: mac_rx_buffer_reader

Overview:
Drain side of the MAC Rx packet buffer; runs in the 250 MHz PCIe-side clock domain.
- Watches the committed write pointer published by the 156.25 MHz MAC Rx writer.
- Reads each committed packet (header word + data words) from the 512x64 dual-port RAM and presents it as a valid/ready stream with sop/eop/keep/len to the DMA engine.
- Returns the extended read pointer to the writer for overrun avoidance.

Parameters:
ADDR_W, 9, RAM word address width; pointers are ADDR_W+1 bits (wrap bit included).
MAX_LEN, 1522, largest legal frame byte count; any larger header value is treated as corruption.

Ports:
clk  in  1  250 MHz clock
reset  in  1  synchronous, active-high reset
commited_wr_address  in  ADDR_W+1  writer's commit pointer; foreign (156.25 MHz) domain
rd_addr_extended  out  ADDR_W+1  read pointer returned to writer; first word not yet freed
rd_addr  out  ADDR_W  RAM read port address
rd_en  out  1  RAM read enable
rd_data  in  64  RAM read data, valid exactly 1 cycle after rd_en
m_data  out  64  stream data, byte 0 in [7:0]
m_keep  out  8  byte enables, LSB-contiguous
m_sop  out  1  first word of packet
m_eop  out  1  last word of packet
m_len  out  16  packet byte count, valid with m_sop
m_valid  out  1  stream valid
m_ready  in  1  stream ready
err_resync  out  1  one-cycle pulse on corrupt header
pkt_count  out  32  packets delivered (RX_STATS_EN)
byte_count  out  32  bytes delivered (RX_STATS_EN)

Behaviour:
- Reset: rd_addr_extended=0, rd_addr=0, rd_en=0, m_valid/m_sop/m_eop=0, m_keep=0, m_len=0, m_data=0, err_resync=0, counters=0, commit_sync=0, FSM=IDLE, skid buffer empty.
- CDC: commited_wr_address passes through two flops (c0, c1). commit_sync loads c1 only when c0==c1, which filters multi-bit transitions.
- Buffer layout per packet starting at pointer S:
  - word S holds the header; [63:32] is the byte count L.
  - words S+1..S+N hold data, with N=ceil(L/8).
  - the next packet starts at S+N+1.
  - all arithmetic is mod 2^(ADDR_W+1); RAM address is ptr[ADDR_W-1:0].
- Empty: rd_ptr==commit_sync. The FSM never reads past commit_sync.
- IDLE: if not empty, rd_en=1, rd_addr=S; go HDR.
- HDR: capture L from rd_data[63:31+1]; compute N and last-word keep. Then:
  - L==0 or L>MAX_LEN: pulse err_resync, set rd_ptr=rd_addr_extended=commit_sync, go IDLE.
  - otherwise: go STREAM.
- STREAM: read words S+1..S+N in order, one per cycle, while the 2-entry skid buffer has room (occupancy + reads in flight < 2).
  - Words enter the skid buffer; the buffer head drives m_*.
  - m_sop=1 on word 1; m_len=L on sop.
  - m_eop=1 on word N. m_keep=8'hFF except on eop, where it is FF if L%8==0, else (1<<(L%8))-1.
  - A single-word packet asserts sop and eop together.
- Transfer occurs when m_valid&&m_ready. m_data/m_keep/m_sop/m_eop/m_len are held stable while m_valid&&!m_ready.
- On the eop transfer: rd_addr_extended<=S+N+1 (whole packet freed at once, never partially) and go IDLE.
- Throughput: with m_ready=1, one word per cycle inside a packet, plus 2 cycles of header overhead per packet.
- Latency: first m_valid exactly 3 cycles after the cycle IDLE sees non-empty.
- Wrap: a packet may straddle RAM address 511→0; reads continue at 0 with no bubble.
- Commit pointer advancing mid-packet has no effect on the packet in progress.
- Reset asserted mid-packet: all state returns to reset values, and the partial packet is not completed (no eop is emitted).

Optional Feature:
RX_STATS_EN
- Defined: pkt_count += 1 and byte_count += L on each eop transfer; both wrap at 2^32. err_resync events do not count.
- Undefined: counter logic is not built; pkt_count and byte_count are tied to 0.

Test Plan:
- Single 60-byte packet at S=0 (header L=60, 8 words), m_ready=1 → 8 words on consecutive cycles; sop on word 1 with m_len=60; eop keep=8'h0F; then rd_addr_extended=9.
- 64-byte packet, m_ready toggling 1,0,0,1,… → no word lost or duplicated, outputs stable while stalled; eop keep=8'hFF; rd_addr_extended=9.
- Packet with S=508, L=40 (5 words across 509..513) → reads at RAM 509,510,511,0,1 with data intact; rd_addr_extended=514.
- Header L=0 at S=20, commit=30 → err_resync pulse, no m_valid, rd_addr_extended=30. Same check with L=2000 (>MAX_LEN).
- Two back-to-back 1-byte packets, m_ready=1 → each word has sop=eop=1, keep=8'h01; rd_addr_extended goes 2 then 4.
- With RX_STATS_EN: 3 packets of 60 bytes → pkt_count=3, byte_count=180. Without the macro, both counters read 0.
